phy_tx_stripe_mux: RTL and testbench

Parametrised successor of the 4-lane PHY transmit multiplexer, running in a single clock domain. It accepts LANES parallel W-bit lane inputs, each with its own valid, and buffers each lane in a DEPTH-entry FIFO. The buffered words are drained onto one W-bit output stream in strict lane order (0,1,...,LANES-1,0,...), so byte-striping order is preserved. The block sits between the lane striping logic and the serializer/encoder, and supports downstream backpressure.

---
 rtl/phy_tx_stripe_mux.sv | 146 ++++++++++++++
 tb/tb_phy_tx_stripe_mux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_stripe_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phy_tx_stripe_mux                                            |
// | Description : Per-lane FIFOs drained onto one stream in strict lane order. |
// |               Optional idle-symbol insertion: PHY_TX_IDLE_INSERT_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module phy_tx_stripe_mux #(
  parameter int           LANES    = 4,
  parameter int           W        = 8,
  parameter int           DEPTH    = 4,
  parameter logic [W-1:0] IDLE_SYM = W'(8'hBC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES*W-1:0]       data_in,
  input  logic [LANES-1:0]         valid_in,
  input  logic                     ready_out,
  input  logic                     flush,
  output logic [W-1:0]             data_out,
  output logic                     valid_out,
  output logic                     idle_out,
  output logic [$clog2(LANES)-1:0] lane_ptr,
  output logic [LANES-1:0]         lane_full,
  output logic [LANES-1:0]         lane_empty,
  output logic                     overflow
);

  localparam int c_lw = $clog2(LANES);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [W-1:0]     r_mem [LANES][DEPTH];
  logic [c_aw-1:0]  r_wp  [LANES];
  logic [c_aw-1:0]  r_rp  [LANES];
  logic [c_cw-1:0]  r_cnt [LANES];
  logic [c_lw-1:0]  r_lane_ptr;
  logic [W-1:0]     r_data_out;
  logic             r_valid_out;
  logic             r_overflow;
  logic             w_pop;
  logic [LANES-1:0] w_lane_pop;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_drop;
  logic [W-1:0]     w_head;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_status
    assign lane_full[gi]  = (r_cnt[gi] == c_cw'(DEPTH));
    assign lane_empty[gi] = (r_cnt[gi] == '0);
  end

  // A stall on an empty lane never skips ahead, keeping stripe order strict.
  assign w_pop  = ready_out && !lane_empty[r_lane_ptr];
  assign w_head = r_mem[r_lane_ptr][r_rp[r_lane_ptr]];

  always_comb begin
    w_lane_pop = '0;
    w_push     = '0;
    w_drop     = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_pop[i] = w_pop && (r_lane_ptr == c_lw'(i));
      w_push[i]     = valid_in[i] && (!lane_full[i] || w_lane_pop[i]);
      w_drop[i]     = valid_in[i] && !w_push[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_cnt[i] <= '0;
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
      end
      r_lane_ptr <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < LANES; i++) begin
        r_cnt[i] <= '0;
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
      end
      r_lane_ptr <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_push[i])     r_wp[i] <= r_wp[i] + c_aw'(1);
        if (w_lane_pop[i]) r_rp[i] <= r_rp[i] + c_aw'(1);
        case ({w_push[i], w_lane_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + c_cw'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - c_cw'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      if (w_pop)
        r_lane_ptr <= (r_lane_ptr == c_lw'(LANES - 1)) ? '0 : r_lane_ptr + c_lw'(1);
      if (|w_drop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!flush && w_push[i]) r_mem[i][r_wp[i]] <= data_in[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else if (flush) begin
      r_valid_out <= 1'b0;
    end else if (w_pop) begin
      r_data_out  <= w_head;
      r_valid_out <= 1'b1;
    end else begin
      r_valid_out <= 1'b0;
`ifdef PHY_TX_IDLE_INSERT_EN
      if (ready_out) r_data_out <= IDLE_SYM;
`endif
    end
  end

`ifdef PHY_TX_IDLE_INSERT_EN
  logic r_idle_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_idle_out <= 1'b0;
    else        r_idle_out <= !flush && ready_out && !w_pop;
  end

  assign idle_out = r_idle_out;
`else
  // Idle symbol only matters when insertion is compiled in.
  logic w_unused_idle_sym;
  assign w_unused_idle_sym = ^IDLE_SYM;
  assign idle_out          = 1'b0;
`endif

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign lane_ptr  = r_lane_ptr;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_stripe_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_phy_tx_stripe_mux                                         |
// | Description : Randomised bench for phy_tx_stripe_mux against a queue model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_phy_tx_stripe_mux;

  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [LANES*W-1:0] data_in;
  logic [LANES-1:0]  valid_in;
  logic              ready_out;
  logic              flush;
  logic [W-1:0]      data_out;
  logic              valid_out;
  logic              idle_out;
  logic [1:0]        lane_ptr;
  logic [LANES-1:0]  lane_full;
  logic [LANES-1:0]  lane_empty;
  logic              overflow;

  always #5 clk = ~clk;

  phy_tx_stripe_mux #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .IDLE_SYM(8'hBC)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .flush      (flush),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .idle_out   (idle_out),
    .lane_ptr   (lane_ptr),
    .lane_full  (lane_full),
    .lane_empty (lane_empty),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference: one queue per lane, output stream taken in strict lane rotation.
  logic [7:0] q [LANES][$];
  int         m_ptr;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_idle;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) q[i].delete();
    m_ptr = 0; m_data = 8'h00; m_valid = 1'b0; m_idle = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [31:0] d, input logic [3:0] v,
                            input logic rdy, input logic fl);
    if (fl) begin
      for (int i = 0; i < LANES; i++) q[i].delete();
      m_ptr = 0; m_ovf = 1'b0; m_valid = 1'b0; m_idle = 1'b0;
    end else begin
      if (rdy && q[m_ptr].size() != 0) begin
        m_data  = q[m_ptr].pop_front();
        m_valid = 1'b1;
        m_idle  = 1'b0;
        m_ptr   = (m_ptr + 1) % LANES;
      end else begin
        m_valid = 1'b0;
`ifdef PHY_TX_IDLE_INSERT_EN
        m_idle = rdy;
        if (rdy) m_data = 8'hBC;
`else
        m_idle = 1'b0;
`endif
      end
      // Popping first frees a slot, so a push to a full lane that pops is kept.
      for (int i = 0; i < LANES; i++) begin
        if (v[i]) begin
          if (q[i].size() < DEPTH) q[i].push_back(d[i*8 +: 8]);
          else                     m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] ef, ee;
    for (int i = 0; i < LANES; i++) begin
      ef[i] = (q[i].size() == DEPTH);
      ee[i] = (q[i].size() == 0);
    end
    check("data_out",   data_out,   m_data);
    check("valid_out",  valid_out,  m_valid);
    check("idle_out",   idle_out,   m_idle);
    check("lane_ptr",   lane_ptr,   m_ptr);
    check("lane_full",  lane_full,  ef);
    check("lane_empty", lane_empty, ee);
    check("overflow",   overflow,   m_ovf);
  endtask

  task automatic step(input logic [31:0] d, input logic [3:0] v,
                      input logic rdy, input logic fl);
    data_in = d; valid_in = v; ready_out = rdy; flush = fl;
    @(posedge clk);
    model_edge(d, v, rdy, fl);
    #1;
    compare_all();
  endtask

  // Called just after a step: asserts reset mid-cycle, checks, releases on negedge.
  task automatic async_reset();
    valid_in = '0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    data_in = '0; valid_in = '0; ready_out = 1'b0; flush = 1'b0; reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // One word per lane, drained in order.
    step(32'h44332211, 4'hF, 1'b1, 1'b0);
    repeat (6) step('0, '0, 1'b1, 1'b0);

    // Hole on lane 1 stalls lane 2.
    step(32'h00A200A0, 4'b0101, 1'b1, 1'b0);
    repeat (4) step('0, '0, 1'b1, 1'b0);
    step(32'h0000A100, 4'b0010, 1'b1, 1'b0);
    repeat (4) step('0, '0, 1'b1, 1'b0);

    // Overflow on lane 0, then push while popping a full lane.
    step('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step({24'h0, 8'h50 + 8'(k)}, 4'b0001, 1'b0, 1'b0);
    step(32'h00000055, 4'b0001, 1'b1, 1'b0);
    repeat (3) step('0, '0, 1'b1, 1'b0);

    // Fill all lanes, backpressure, resume.
    step('0, '0, 1'b0, 1'b1);
    repeat (4) step($urandom, 4'hF, 1'b0, 1'b0);
    repeat (2) step('0, '0, 1'b1, 1'b0);
    repeat (3) step('0, '0, 1'b0, 1'b0);
    repeat (3) step('0, '0, 1'b1, 1'b0);

    // Flush with concurrent push, then asynchronous reset mid-drain.
    repeat (2) step($urandom, 4'hF, 1'b1, 1'b0);
    step($urandom, 4'hF, 1'b1, 1'b1);
    repeat (2) step('0, '0, 1'b1, 1'b0);
    repeat (2) step($urandom, 4'hF, 1'b1, 1'b0);
    async_reset();
    repeat (3) step('0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      step($urandom, 4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
